// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into a 32-bit word and queues
// the result, with an error flag, in a 2-entry output FIFO.
// Optional build macro: IMM_CHECK_EN adds immediate range/alignment checking.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] enc_count
);

  localparam int unsigned W_INSTR = 32;
  localparam int unsigned W_CNT   = 16;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned W_ENTRY = W_INSTR + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [W_INSTR-1:0] w_word;
  logic               w_fmt_err;
  logic               w_imm_err;
  logic               w_push;
  logic               w_pop;

  logic [W_ENTRY-1:0] r_mem [DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [W_CNT-1:0]   r_enc_count;

  // Field packing per instruction format; unknown formats give a zero word.
  always_comb begin
    w_word    = '0;
    w_fmt_err = 1'b0;
    unique case (fmt)
      FMT_R: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: w_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: w_word = {imm[31:12], rd, opcode};
      FMT_J: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        w_word    = '0;
        w_fmt_err = 1'b1;
      end
    endcase
  end

`ifdef IMM_CHECK_EN
  // Immediate must be representable: upper bits are pure sign extension.
  always_comb begin
    w_imm_err = 1'b0;
    unique case (fmt)
      FMT_I, FMT_S: w_imm_err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        w_imm_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        w_imm_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        w_imm_err = |imm[11:0];
      default:      w_imm_err = 1'b0;
    endcase
  end
`else
  // Immediate silently truncated; no range error in this build.
  always_comb begin
    w_imm_err = 1'b0;
  end
`endif

  assign in_ready  = (r_count < 2'(DEPTH));
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign instr     = out_valid ? r_mem[r_rd_ptr][W_INSTR-1:0] : '0;
  assign err       = out_valid ? r_mem[r_rd_ptr][W_INSTR] : 1'b0;
  assign enc_count = r_enc_count;

  // FIFO storage, pointers, occupancy and accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_enc_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {(w_fmt_err || w_imm_err), w_word};
        r_wr_ptr        <= ~r_wr_ptr;
        r_enc_count     <= r_enc_count + W_CNT'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, backpressure
// and reset sequences, then randomized traffic against a queue-based model.
module tb_instr_encoder;

`ifdef IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] enc_count;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[9];
  logic [32:0] mq[$];
  int          m_cnt;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the field layout, with signed range checks.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    int          s;
    logic [31:0] base;
    s    = int'(signed'(im));
    base = 32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20);
    e    = 1'b0;
    case (f)
      3'd0: w = base | (32'(f7) << 25);
      3'd1: begin
        w = (32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15)) | ((im & 32'hFFF) << 20);
        e = CHK && (s < -2048 || s > 2047);
      end
      3'd2: begin
        w = (base & ~32'hF80) | ((im & 32'h1F) << 7) | (((im >> 5) & 32'h7F) << 25);
        e = CHK && (s < -2048 || s > 2047);
      end
      3'd3: begin
        w = (base & ~32'hF80) | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
          | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
        e = CHK && (s < -4096 || s > 4094 || (s % 2) != 0);
      end
      3'd4: begin
        w = 32'(op) | (32'(d) << 7) | (im & 32'hFFFF_F000);
        e = CHK && ((im & 32'hFFF) != 0);
      end
      3'd5: begin
        w = 32'(op) | (32'(d) << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
          | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
        e = CHK && (s < -1048576 || s > 1048574 || (s % 2) != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    check({tag, ".enc_count"}, 32'(enc_count), 32'(m_cnt & 16'hFFFF));
    if (mq.size() != 0) begin
      check({tag, ".instr"}, instr, mq[0][31:0]);
      check({tag, ".err"},   32'(err), 32'(mq[0][32]));
    end
  endtask

  // One clock: update the model with the handshakes of this edge, then compare.
  task automatic tick(input string tag);
    bit acc, pop;
    @(posedge clk);
    if (!rst) begin
      acc = in_valid && (mq.size() < 2);
      pop = out_ready && (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
        m_cnt++;
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.opcode; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.funct3; funct7 = v.funct7; imm = v.imm;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; m_cnt = 0;
    //         fmt   opcode       rd  rs1 rs2 f3     f7        imm             instr         err
    vecs[0] = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093, 1'b0};
    vecs[1] = '{3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,        32'h0020A423, 1'b0};
    vecs[2] = '{3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,          32'h00208463, 1'b0};
    vecs[3] = '{3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9,          32'h00208463, CHK};
    vecs[4] = '{3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7, 1'b0};
    vecs[5] = '{3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF,  32'h002081B3, 1'b0};
    vecs[6] = '{3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h008000EF, 1'b0};
    vecs[7] = '{3'd6, 7'b0010011, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd5,          32'h00000000, 1'b1};
    vecs[8] = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,       32'h00000093, CHK};

    // Reset held from time zero, checked before any clock edge.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    #1;
    check("rst0.out_valid", 32'(out_valid), 32'd0);
    check("rst0.in_ready",  32'(in_ready),  32'd1);
    check("rst0.instr",     instr,          32'd0);
    check("rst0.err",       32'(err),       32'd0);
    check("rst0.enc_count", 32'(enc_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: three requests with the consumer stalled, then drain.
    out_ready = 1'b0; in_valid = 1'b1;
    drive(vecs[0]); tick("bp1");
    drive(vecs[1]); tick("bp2");
    check("bp.in_ready_full", 32'(in_ready), 32'd0);
    drive(vecs[4]); tick("bp3_held");
    check("bp.count_held", 32'(enc_count), 32'd2);
    check("bp.head_a", instr, 32'h00500093);
    out_ready = 1'b1;
    tick("bp_drain1");
    check("bp.head_b", instr, 32'h0020A423);
    tick("bp_drain2");
    check("bp.head_c", instr, 32'h123452B7);
    in_valid = 1'b0;
    tick("bp_drain3");
    check("bp.empty", 32'(out_valid), 32'd0);
    check("bp.enc_count", 32'(enc_count), 32'd3);

    // Directed vector table, one request at a time with one-cycle latency.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d.instr", i), instr, vecs[i].exp_instr);
      check($sformatf("vec%0d.err", i),   32'(err), 32'(vecs[i].exp_err));
      in_valid = 1'b0;
      tick($sformatf("vec%0d_pop", i));
    end

    // Reset mid-operation with two words queued.
    out_ready = 1'b0; in_valid = 1'b1;
    drive(vecs[1]); tick("rq1");
    drive(vecs[2]); tick("rq2");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete(); m_cnt = 0;
    check("rst1.out_valid", 32'(out_valid), 32'd0);
    check("rst1.in_ready",  32'(in_ready),  32'd1);
    check("rst1.enc_count", 32'(enc_count), 32'd0);
    check("rst1.instr",     instr,          32'd0);
    check("rst1.err",       32'(err),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[6]); in_valid = 1'b1; out_ready = 1'b1;
    tick("post_rst_accept");
    check("post_rst.instr", instr, 32'h008000EF);
    in_valid = 1'b0;
    tick("post_rst_pop");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      fmt    = 3'($urandom_range(0, 7));
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
      rs2 = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        2:       imm = 32'($urandom_range(0, 4000000)) - 32'd2000000;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
